// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types for the PPU table loader.
//   tbl_e       - table select encoding carried in address[9:8]
//   ppu_cmd_t   - one queued table-update command (42 bits)
//   ldr_state_e - loader FSM states
//   cmd_is_valid() - range check applied when a command is popped
package ppu_pkg;

  typedef enum logic [1:0] {
    TBL_ATTR   = 2'b00,
    TBL_SPRITE = 2'b01,
    TBL_COLOR  = 2'b10,
    TBL_BAD    = 2'b11
  } tbl_e;

  localparam int ATTR_ENTRIES   = 16;
  localparam int SPRITE_ENTRIES = 256;
  localparam int COLOR_ENTRIES  = 16;

  typedef struct packed {
    tbl_e        tbl;
    logic [7:0]  index;
    logic [31:0] data;
  } ppu_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GATE  = 2'b01,
    ISSUE = 2'b10
  } ldr_state_e;

  // True when the index lies inside the selected table; TBL_BAD never does.
  function automatic logic cmd_is_valid(input ppu_cmd_t cmd);
    logic       v_ok;
    logic [8:0] v_idx;
    v_idx = {1'b0, cmd.index};
    case (cmd.tbl)
      TBL_ATTR:   v_ok = (v_idx < 9'(ATTR_ENTRIES));
      TBL_SPRITE: v_ok = (v_idx < 9'(SPRITE_ENTRIES));
      TBL_COLOR:  v_ok = (v_idx < 9'(COLOR_ENTRIES));
      default:    v_ok = 1'b0;
    endcase
    return v_ok;
  endfunction

endpackage

// File: rtl/ppu_loader_sync_fifo.sv
// sync_fifo: single-clock FIFO of ppu_cmd_t with first-word fall-through read.
//   clk, reset      - clock, asynchronous active-high reset
//   i_push, i_data  - write request/data (ignored while full)
//   i_pop, o_data   - read request (ignored while empty) / head entry
//   o_full, o_empty, o_count - registered occupancy status
module sync_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  ppu_cmd_t                 i_data,
  input  logic                     i_pop,
  output ppu_cmd_t                 o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ppu_cmd_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == {CW{1'b0}});
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ppu_loader.sv
// ppu_loader: queues PPU table-update commands and replays each as a
// single-cycle chipselect/write on the PPU write port.
//   clk, reset                        - 50 MHz clock, async active-high reset
//   in_valid/in_ready                 - command stream handshake
//   in_table/in_index/in_data         - command fields
//   vblank                            - vertical blank (used only when gated)
//   chipselect/write/address/writedata- registered PPU write port
//   busy                              - queue non-empty or write on the bus
//   err/drop_count                    - sticky drop flag / saturating drop count
// Build option: define VBLANK_GATE_EN to issue writes only while vblank=1.
module ppu_loader
  import ppu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_table,
  input  logic [7:0]  in_index,
  input  logic [31:0] in_data,
  input  logic        vblank,
  output logic        chipselect,
  output logic        write,
  output logic [15:0] address,
  output logic [31:0] writedata,
  output logic        busy,
  output logic        err,
  output logic [7:0]  drop_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  ldr_state_e      r_state;
  ldr_state_e      w_next_state;
  ppu_cmd_t        w_in_cmd;
  ppu_cmd_t        w_head;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic            w_push;
  logic            w_pop;
  logic            w_permit;
  logic            w_head_ok;
  logic            w_last;
  logic            r_cs;
  logic [15:0]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_err;
  logic [7:0]      r_drop_count;

`ifdef VBLANK_GATE_EN
  assign w_permit = vblank;
`else
  logic w_unused_vblank;
  assign w_unused_vblank = vblank;
  assign w_permit        = 1'b1;
`endif

  assign w_in_cmd  = '{tbl: tbl_e'(in_table), index: in_index, data: in_data};
  assign in_ready  = !w_full;
  assign w_push    = in_valid && in_ready;
  // The permit is examined right before the edge, so the first pop of a
  // burst happens on the same edge that moves the FSM out of IDLE/GATE.
  assign w_pop     = !w_empty && w_permit;
  assign w_head_ok = cmd_is_valid(w_head);
  // This pop drains the queue unless a new command lands on the same edge.
  assign w_last    = (w_count == CW'(1)) && !w_push;

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_in_cmd),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state; GATE is bypassed whenever the permit is already present.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_empty) begin
          w_next_state = IDLE;
        end else if (!w_permit) begin
          w_next_state = GATE;
        end else if (w_last) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = ISSUE;
        end
      end
      GATE: begin
        if (w_empty) begin
          w_next_state = IDLE;
        end else if (!w_permit) begin
          w_next_state = GATE;
        end else if (w_last) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (w_empty) begin
          w_next_state = IDLE;
        end else if (!w_permit) begin
          w_next_state = GATE;
        end else if (w_last) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = ISSUE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Bus write port and drop accounting; each pop lasts exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cs         <= 1'b0;
      r_addr       <= 16'h0000;
      r_wdata      <= 32'h0000_0000;
      r_err        <= 1'b0;
      r_drop_count <= 8'h00;
    end else begin
      r_cs <= w_pop && w_head_ok;
      if (w_pop && w_head_ok) begin
        r_addr  <= {6'b000000, w_head.tbl, w_head.index};
        r_wdata <= w_head.data;
      end
      if (w_pop && !w_head_ok) begin
        r_err <= 1'b1;
        if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 8'd1;
        end
      end
    end
  end

  assign chipselect = r_cs;
  assign write      = r_cs;
  assign address    = r_addr;
  assign writedata  = r_wdata;
  assign err        = r_err;
  assign drop_count = r_drop_count;
  assign busy       = !w_empty || r_cs;

endmodule
